inv_sub_bytes_seq: RTL and testbench

Iterative InvSubBytes engine for the AES-128 decryption datapath. It is the inverse of the existing fully-parallel 16-S-box SubBytes stage. It accepts a 128-bit state over a valid/ready handshake and substitutes BPC bytes per cycle through BPC inverse S-box lookups, trading latency for area. It returns the 128-bit result on an output valid/ready handshake to the InvShiftRows/AddRoundKey stages of the decryption round.

---
 rtl/inv_sub_bytes_seq.sv | 113 +++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - Iterative AES-128 InvSubBytes engine, BPC bytes per clock
module inv_sub_bytes_seq #(
   parameter int BPC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   localparam int NCYC = 16 / BPC;
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam int GW   = 8 * BPC;
   localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

   generate
      if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bad_bpc
         $error("inv_sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [127:0]    r_data;
   logic [127:0]    w_data_sub;
   logic [GW-1:0]   w_grp;
   logic [GW-1:0]   w_grp_sub;
   logic [GW-1:0]   w_grp_opts [2**CW];
   logic            w_last;

   assign w_last = (r_cnt == CNT_LAST);

   // Select the active byte group once so only BPC S-box tables are built.
   generate
      for (genvar j = 0; j < 2**CW; j++) begin : g_grp_sel
         if (j < NCYC) begin : g_real
            assign w_grp_opts[j] = r_data[127 - GW*j -: GW];
            assign w_data_sub[127 - GW*j -: GW] =
               (r_cnt == CW'(j)) ? w_grp_sub : r_data[127 - GW*j -: GW];
         end else begin : g_pad
            assign w_grp_opts[j] = '0;
         end
      end
      for (genvar g = 0; g < BPC; g++) begin : g_lane
         assign w_grp_sub[GW-1 - 8*g -: 8] = INV_SBOX[w_grp[GW-1 - 8*g -: 8]];
      end
   endgenerate

   assign w_grp = w_grp_opts[r_cnt];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
         S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_data <= in_data;
                  r_cnt  <= '0;
               end
            end
            S_BUSY: begin
               r_data <= w_data_sub;
               r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_BUSY) || (r_state == S_DONE);
   assign out_data  = r_data;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - Self-checking bench for inv_sub_bytes_seq (BPC 1, 4, 16)
module tb_inv_sub_bytes_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic         busy      [3];
   logic [127:0] in_data   [3];
   logic [127:0] out_data  [3];

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [127:0] exp_q [$];
   logic [7:0]   inv_tbl [256];

   // Forward FIPS-197 S-box; the inverse reference is derived from it at run time.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   inv_sub_bytes_seq #(.BPC(1)) u_bpc1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .busy(busy[0]));
   inv_sub_bytes_seq #(.BPC(4)) u_bpc4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .busy(busy[1]));
   inv_sub_bytes_seq #(.BPC(16)) u_bpc16 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .busy(busy[2]));

   function automatic int ncyc(input int i);
      return (i == 0) ? 16 : (i == 1) ? 4 : 1;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] x);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = SBOX[x[127-8*k -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] x);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tbl[x[127-8*k -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [127:0] d);
      int n = 0;
      while (!in_ready[i] && n < 100) begin
         cycle();
         n++;
      end
      check("send_in_ready", {127'd0, in_ready[i]}, 128'd1);
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      cycle();
      in_valid[i] = 1'b0;
      in_data[i]  = rnd128();
      check("busy_after_accept", {127'd0, busy[i]}, 128'd1);
   endtask

   task automatic recv(input int i, input int exp_lat, input string tag);
      int n = 0;
      logic [127:0] e;
      while (!out_valid[i] && n < 200) begin
         cycle();
         n++;
      end
      check({tag, "_latency"}, 128'(n), 128'(exp_lat));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      check(tag, out_data[i], e);
      out_ready[i] = 1'b1;
      cycle();
      out_ready[i] = 1'b0;
      check({tag, "_in_ready_back"}, {127'd0, in_ready[i]}, 128'd1);
   endtask

   initial begin
      logic [127:0] d;
      logic [127:0] x;
      logic [127:0] blk [3];
      int           acc [3];
      int           k, got, cyc;
      logic         seen_ov;

      for (int v = 0; v < 256; v++) inv_tbl[SBOX[v]] = 8'(v);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0;
      end

      // Reset state, then a quiet idle period.
      cycle(); cycle();
      for (int i = 0; i < 3; i++) begin
         check("rst_in_ready",  {127'd0, in_ready[i]},  128'd1);
         check("rst_out_valid", {127'd0, out_valid[i]}, 128'd0);
         check("rst_busy",      {127'd0, busy[i]},      128'd0);
         check("rst_out_data",  out_data[i], 128'd0);
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) cycle();
      for (int i = 0; i < 3; i++) begin
         check("idle_in_ready",  {127'd0, in_ready[i]},  128'd1);
         check("idle_out_valid", {127'd0, out_valid[i]}, 128'd0);
         check("idle_out_data",  out_data[i], 128'd0);
      end

      // BPC=1, all 0x63: first BUSY edge only touches byte 0.
      send(0, {16{8'h63}});
      cycle();
      check("bpc1_partial", out_data[0], {8'h00, {15{8'h63}}});
      exp_q.push_back(128'd0);
      recv(0, 15, "bpc1_63");

      // BPC=4 mixed spot values with a 10-cycle output stall.
      d = 128'h00637CED_16FF0000_637C16FF_ED000063;
      send(1, d);
      k = 0;
      while (!out_valid[1] && k < 50) begin
         cycle();
         k++;
      end
      check("bpc4_latency", 128'(k), 128'd4);
      check("bpc4_data", out_data[1], 128'h52000153_FF7D5252_0001FF7D_53525200);
      for (int c = 0; c < 10; c++) begin
         in_valid[1] = c[0];
         cycle();
         check("stall_data",      out_data[1], 128'h52000153_FF7D5252_0001FF7D_53525200);
         check("stall_out_valid", {127'd0, out_valid[1]}, 128'd1);
         check("stall_in_ready",  {127'd0, in_ready[1]},  128'd0);
      end
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b1;
      cycle();
      out_ready[1] = 1'b0;
      check("stall_release_in_ready",  {127'd0, in_ready[1]},  128'd1);
      check("stall_release_out_valid", {127'd0, out_valid[1]}, 128'd0);

      // Reset in the middle of a BPC=1 block discards it.
      send(0, rnd128());
      seen_ov = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cycle();
         seen_ov |= out_valid[0];
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midrst_in_ready", {127'd0, in_ready[0]}, 128'd1);
      check("midrst_busy",     {127'd0, busy[0]},     128'd0);
      check("midrst_out_data", out_data[0], 128'd0);
      for (int c = 0; c < 20; c++) begin
         cycle();
         seen_ov |= out_valid[0];
      end
      check("midrst_no_output", {127'd0, seen_ov}, 128'd0);
      x = rnd128();
      exp_q.push_back(inv_sub(x));
      send(0, x);
      recv(0, 16, "after_midrst");

      // Back-to-back on BPC=4 with in_valid held/toggled and out_ready high.
      for (int b = 0; b < 3; b++) blk[b] = rnd128();
      k = 0; got = 0; cyc = 0;
      out_ready[1] = 1'b1;
      while (got < 3 && cyc < 200) begin
         if (in_ready[1] && k < 3) begin
            in_valid[1] = 1'b1;
            in_data[1]  = blk[k];
            exp_q.push_back(inv_sub(blk[k]));
            acc[k] = cyc;
            k++;
         end else if (busy[1]) begin
            in_valid[1] = 1'($urandom_range(0, 1));
            in_data[1]  = rnd128();
         end else begin
            in_valid[1] = 1'b0;
         end
         if (out_valid[1]) begin
            check("b2b_data", out_data[1], (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
            got++;
         end
         cycle();
         cyc++;
      end
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b0;
      check("b2b_count", 128'(got), 128'd3);
      check("b2b_interval_01", 128'(acc[1] - acc[0]), 128'(ncyc(1) + 2));
      check("b2b_interval_12", 128'(acc[2] - acc[1]), 128'(ncyc(1) + 2));
      cycle();
      check("b2b_idle", {127'd0, in_ready[1]}, 128'd1);

      // Every byte value in all 16 lanes on BPC=16.
      for (int v = 0; v < 256; v++) begin
         exp_q.push_back({16{inv_tbl[v]}});
         send(2, {16{8'(v)}});
         recv(2, 1, "all256");
      end

      // Round trip SubBytes -> InvSubBytes for BPC=1 and BPC=16.
      for (int t = 0; t < 1000; t++) begin
         x = rnd128();
         exp_q.push_back(x);
         send(0, sub_bytes(x));
         recv(0, ncyc(0), "roundtrip_bpc1");
         x = rnd128();
         exp_q.push_back(x);
         send(2, sub_bytes(x));
         recv(2, ncyc(2), "roundtrip_bpc16");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
